// File: rtl/ibex_pkg_pext.sv
// ibex_pkg_pext: Pext operator encodings and MAC sequencer types
package ibex_pkg_pext;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ZPN_INSTR = 2'd2
  } alu_op_e;

  typedef enum logic [3:0] {
    ZPN_ADD16   = 4'd0,
    ZPN_SUB16   = 4'd1,
    ZPN_MADDR32 = 4'd2,
    ZPN_MSUBR32 = 4'd3,
    ZPN_KMMAC   = 4'd4,
    ZPN_KMMACU  = 4'd5,
    ZPN_KMMSB   = 4'd6,
    ZPN_KMMSBU  = 4'd7
  } zpn_op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PP0  = 3'd1,
    PP1  = 3'd2,
    PP2  = 3'd3,
    PP3  = 3'd4,
    ACC  = 3'd5,
    DONE = 3'd6
  } mac_seq_state_e;

  localparam logic [63:0] MAC_RND_INIT = 64'h0000_0000_8000_0000;

  function automatic logic is_mac_op(zpn_op_e op);
    return op inside {ZPN_MADDR32, ZPN_MSUBR32, ZPN_KMMAC, ZPN_KMMACU, ZPN_KMMSB, ZPN_KMMSBU};
  endfunction

  function automatic logic is_rnd_op(zpn_op_e op);
    return op inside {ZPN_KMMACU, ZPN_KMMSBU};
  endfunction

  // MADDR32/MSUBR32 consume the low product word, KMM* the high word
  function automatic logic is_low_word_op(zpn_op_e op);
    return op inside {ZPN_MADDR32, ZPN_MSUBR32};
  endfunction

endpackage

// File: rtl/ibex_pext_mul17.sv
// ibex_pext_mul17: combinational signed 17x17 -> 34 multiplier
module ibex_pext_mul17 (
  input  logic signed [16:0] a_i,
  input  logic signed [16:0] b_i,
  output logic signed [33:0] p_o
);
  assign p_o = a_i * b_i;
endmodule

// File: rtl/ibex_pext_mac_seq.sv
// ibex_pext_mac_seq: four-cycle 32x32 product build, then one ALU slot for the Pext MAC op
module ibex_pext_mac_seq
  import ibex_pkg_pext::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        kill_i,
  input  zpn_op_e     zpn_operator_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic [31:0] op_c_i,
  output logic        busy_o,
  output logic        alu_req_o,
  input  logic        alu_gnt_i,
  output alu_op_e     alu_operator_o,
  output zpn_op_e     zpn_operator_o,
  output logic [31:0] alu_operand_a_o,
  output logic [31:0] alu_operand_b_o,
  input  logic [31:0] alu_result_i,
  input  logic        alu_ov_i,
  output logic        valid_o,
  output logic [31:0] result_o,
  output logic        ov_o
);
  mac_seq_state_e state_q, state_d;
  zpn_op_e op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d, c_q, c_d, result_q, result_d;
  logic [63:0] acc_q, acc_d, pp_ext, pp_sh;
  logic ov_q, ov_d, accept, pp_active, in_acc, grant;
  logic signed [16:0] mul_a, mul_b;
  logic signed [33:0] mul_p;

  assign in_acc    = state_q == ACC;
  assign pp_active = state_q inside {PP0, PP1, PP2, PP3};
  assign accept    = !kill_i && state_q == IDLE && en_i && is_mac_op(zpn_operator_i);
  assign grant     = !kill_i && in_acc && alu_gnt_i;

  // high halves are signed, low halves unsigned, so every partial product fits 17x17
  assign mul_a = state_q inside {PP2, PP3} ? {a_q[31], a_q[31:16]} : {1'b0, a_q[15:0]};
  assign mul_b = state_q inside {PP1, PP3} ? {b_q[31], b_q[31:16]} : {1'b0, b_q[15:0]};

  ibex_pext_mul17 u_mul (.a_i(mul_a), .b_i(mul_b), .p_o(mul_p));

  assign pp_ext = {{30{mul_p[33]}}, mul_p};
  assign pp_sh  = state_q == PP3 ? pp_ext << 32 : state_q inside {PP1, PP2} ? pp_ext << 16 : pp_ext;

  always_comb begin
    state_d = state_q;
    if (kill_i) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:    state_d = accept ? PP0 : IDLE;
        PP0:     state_d = PP1;
        PP1:     state_d = PP2;
        PP2:     state_d = PP3;
        PP3:     state_d = ACC;
        ACC:     state_d = alu_gnt_i ? DONE : ACC;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    op_d     = accept ? zpn_operator_i : op_q;
    a_d      = accept ? op_a_i : a_q;
    b_d      = accept ? op_b_i : b_q;
    c_d      = accept ? op_c_i : c_q;
    acc_d    = accept ? (is_rnd_op(zpn_operator_i) ? MAC_RND_INIT : '0) :
               pp_active ? acc_q + pp_sh : acc_q;
    result_d = grant ? alu_result_i : result_q;
    ov_d     = grant ? alu_ov_i : ov_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      op_q     <= ZPN_ADD16;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      ov_q     <= ov_d;
    end
  end

  assign busy_o          = state_q != IDLE;
  assign alu_req_o       = in_acc;
  assign alu_operator_o  = in_acc ? ZPN_INSTR : ALU_ADD;
  assign zpn_operator_o  = in_acc ? op_q : ZPN_ADD16;
  assign alu_operand_a_o = in_acc ? c_q : '0;
  assign alu_operand_b_o = !in_acc ? '0 : is_low_word_op(op_q) ? acc_q[31:0] : acc_q[63:32];
  assign valid_o         = state_q == DONE && !kill_i;
  assign result_o        = result_q;
  assign ov_o            = ov_q;
endmodule

// File: tb/tb_ibex_pext_mac_seq.sv
// tb_ibex_pext_mac_seq: scoreboard bench with a behavioural ALU and 64-bit product reference
module tb_ibex_pext_mac_seq;
  import ibex_pkg_pext::*;

  logic clk_i = 0, rst_ni = 0, en_i = 0, kill_i = 0, alu_gnt_i = 1, alu_ov_i;
  zpn_op_e zpn_operator_i = ZPN_ADD16, zpn_operator_o;
  alu_op_e alu_operator_o;
  logic [31:0] op_a_i = 0, op_b_i = 0, op_c_i = 0;
  logic [31:0] alu_operand_a_o, alu_operand_b_o, alu_result_i, result_o;
  logic busy_o, alu_req_o, valid_o, ov_o;

  int tests = 0, fails = 0, cyc = 0, stall_left = 0;

  typedef struct {
    zpn_op_e op;
    logic [31:0] rd, word, res;
    logic ov;
    int vcyc;
  } exp_t;
  exp_t sb[$];

  ibex_pext_mac_seq dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .kill_i(kill_i),
    .zpn_operator_i(zpn_operator_i), .op_a_i(op_a_i), .op_b_i(op_b_i), .op_c_i(op_c_i),
    .busy_o(busy_o), .alu_req_o(alu_req_o), .alu_gnt_i(alu_gnt_i),
    .alu_operator_o(alu_operator_o), .zpn_operator_o(zpn_operator_o),
    .alu_operand_a_o(alu_operand_a_o), .alu_operand_b_o(alu_operand_b_o),
    .alu_result_i(alu_result_i), .alu_ov_i(alu_ov_i),
    .valid_o(valid_o), .result_o(result_o), .ov_o(ov_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // behavioural ALU: wrapping add/sub for MADDR32/MSUBR32, signed saturation with OV for KMM*
  function automatic logic [32:0] alu_fn(zpn_op_e op, logic [31:0] x, logic [31:0] y);
    longint s;
    case (op)
      ZPN_MADDR32: return {1'b0, x + y};
      ZPN_MSUBR32: return {1'b0, x - y};
      ZPN_KMMAC, ZPN_KMMACU: s = longint'($signed(x)) + longint'($signed(y));
      ZPN_KMMSB, ZPN_KMMSBU: s = longint'($signed(x)) - longint'($signed(y));
      default: return '0;
    endcase
    if (s > longint'(32'sh7FFF_FFFF)) return {1'b1, 32'h7FFF_FFFF};
    if (s < longint'(-32'sh8000_0000)) return {1'b1, 32'h8000_0000};
    return {1'b0, s[31:0]};
  endfunction

  // reference product word: full signed 64-bit multiply, optional rounding, word pick
  function automatic logic [31:0] ref_word(zpn_op_e op, logic [31:0] a, logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    if (op == ZPN_KMMACU || op == ZPN_KMMSBU) p = p + 64'h8000_0000;
    return (op == ZPN_MADDR32 || op == ZPN_MSUBR32) ? p[31:0] : p[63:32];
  endfunction

  assign {alu_ov_i, alu_result_i} = alu_fn(zpn_operator_o, alu_operand_a_o, alu_operand_b_o);

  task automatic check(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(zpn_op_e op, logic [31:0] a, logic [31:0] b, logic [31:0] c, int stalls, bit track);
    exp_t e;
    logic [32:0] r;
    en_i = 1; zpn_operator_i = op; op_a_i = a; op_b_i = b; op_c_i = c; stall_left = stalls;
    if (track) begin
      e.op = op; e.rd = c; e.word = ref_word(op, a, b);
      r = alu_fn(op, c, e.word);
      e.res = r[31:0]; e.ov = r[32]; e.vcyc = cyc + 6 + stalls;
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy_o; i++) step();
    check("idle_timeout", 32'(busy_o), 32'd0);
  endtask

  // accept, then three cycles of en_i with junk operands that must be ignored
  task automatic run(zpn_op_e op, logic [31:0] a, logic [31:0] b, logic [31:0] c, int stalls);
    step();
    drive(op, a, b, c, stalls, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      zpn_operator_i = zpn_op_e'($urandom_range(0, 7));
      op_a_i = $urandom; op_b_i = $urandom; op_c_i = $urandom;
    end
    step();
    en_i = 0;
    wait_idle();
  endtask

  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (alu_req_o && stall_left > 0) begin
        alu_gnt_i = 0;
        stall_left--;
      end else alu_gnt_i = 1;
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (alu_req_o) begin
        if (sb.size() == 0) check("unexpected_req", 32'(alu_req_o), 32'd0);
        else begin
          check("operand_b", alu_operand_b_o, sb[0].word);
          check("operand_a", alu_operand_a_o, sb[0].rd);
          check("zpn_op", 32'(zpn_operator_o), 32'(sb[0].op));
          check("alu_op", 32'(alu_operator_o), 32'(ZPN_INSTR));
        end
      end
      if (valid_o) begin
        if (sb.size() == 0) check("unexpected_valid", 32'(valid_o), 32'd0);
        else begin
          e = sb.pop_front();
          check("result", result_o, e.res);
          check("ov", 32'(ov_o), 32'(e.ov));
          check("latency", 32'(cyc), 32'(e.vcyc));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int t;
    #2;
    check("rst_busy", 32'(busy_o), 0);
    check("rst_req", 32'(alu_req_o), 0);
    check("rst_valid", 32'(valid_o), 0);
    check("rst_result", result_o, 0);
    check("rst_alu_op", 32'(alu_operator_o), 32'(ALU_ADD));
    check("rst_zpn_op", 32'(zpn_operator_o), 32'(ZPN_ADD16));
    @(negedge clk_i);
    rst_ni = 1;
    run(ZPN_MADDR32, 3, 5, 10, 0);
    run(ZPN_MSUBR32, 32'hFFFF_FFFF, 2, 0, 0);
    run(ZPN_KMMAC, 32'h4000_0000, 32'h4000_0000, 32'h7FFF_FFF0, 0);
    run(ZPN_KMMAC, 32'h0001_0000, 32'h0000_8000, 0, 0);
    run(ZPN_KMMACU, 32'h0001_0000, 32'h0000_8000, 0, 0);
    run(ZPN_KMMSBU, 32'h0001_0000, 32'h0000_8000, 0, 0);
    run(ZPN_MADDR32, 32'h1234_5678, 32'h9ABC_DEF0, 32'h1111_1111, 3);
    // unsupported op ignored
    step();
    en_i = 1; zpn_operator_i = ZPN_ADD16;
    step();
    en_i = 0;
    check("ign_busy", 32'(busy_o), 0);
    check("ign_req", 32'(alu_req_o), 0);
    // kill in the accept cycle wins
    en_i = 1; kill_i = 1; zpn_operator_i = ZPN_KMMAC;
    step();
    en_i = 0; kill_i = 0;
    check("kill_accept_busy", 32'(busy_o), 0);
    // kill at T+2, new op at T+3
    drive(ZPN_KMMSB, $urandom, $urandom, $urandom, 0, 0);
    t = cyc;
    step();
    en_i = 0;
    step();
    kill_i = 1;
    step();
    kill_i = 0;
    check("kill_busy", 32'(busy_o), 0);
    check("kill_cycle", 32'(cyc - t), 3);
    drive(ZPN_KMMSB, 32'h0003_0000, 32'hFFFF_0000, 32'h8000_0005, 0, 1);
    step();
    en_i = 0;
    check("post_kill_accept", 32'(busy_o), 1);
    wait_idle();
    // reset during PP2
    step();
    drive(ZPN_KMMACU, $urandom, $urandom, $urandom, 0, 0);
    step();
    en_i = 0;
    step();
    step();
    rst_ni = 0;
    #1;
    check("midrst_busy", 32'(busy_o), 0);
    check("midrst_result", result_o, 0);
    check("midrst_ov", 32'(ov_o), 0);
    check("midrst_opb", alu_operand_b_o, 0);
    @(negedge clk_i);
    rst_ni = 1;
    repeat (10) step();
    for (int i = 0; i < 40; i++)
      run(zpn_op_e'($urandom_range(2, 7)), pick(), pick(), pick(), $urandom_range(0, 2));
    repeat (5) step();
    check("sb_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
